inout_pair_sequencer: RTL and testbench
=======================================

// Module: inout_pair_sequencer
// PURPOSE
// - Drives the address port of the 64x16 index-pair ROM and streams its contents downstream.
// - Sweeps addresses 0..NUM_WORDS-1 once per start, absorbing the ROM's 1-cycle registered latency.
// - Splits each ROM word into an even/odd coefficient index pair on a valid/ready output.
// - Feeds the NTT coefficient-fetch stage. Downstream back-pressure never drops or duplicates a pair.
// PARAMETERS
// - ADDR_W     6    ROM address width
// - IDX_W      8    width of one coefficient index (ROM word = 2*IDX_W)
// - NUM_WORDS  64   words swept per run (<= 2**ADDR_W)
// PORTS
// - clk         in   1         single clock, all logic on posedge
// - rst         in   1         synchronous, active-high reset
// - start       in   1         1-cycle request to begin a sweep; ignored unless IDLE
// - busy        out  1         high from start acceptance until done
// - done        out  1         1-cycle pulse after the final pair handshakes
// - rom_addr    out  ADDR_W   address to the ROM; ROM returns data one clk later
// - rom_data    in   2*IDX_W  registered ROM output for the address issued last cycle
// - out_valid   out  1         output pair valid
// - out_ready   in   1         downstream accepts; handshake = out_valid & out_ready
// - out_idx_hi  out  IDX_W     rom_data[2*IDX_W-1:IDX_W] (even index)
// - out_idx_lo  out  IDX_W     rom_data[IDX_W-1:0] (odd index)
// - out_last    out  1         qualifies the pair read from address NUM_WORDS-1
// BEHAVIOUR
// - Reset state: IDLE. rom_addr=0, busy=0, done=0, out_valid=0, out_idx_*=0, out_last=0.
// - Reset also clears the FIFO, the in-flight flag and the issue counter.
// - Reset mid-run aborts the sweep. No done pulse follows.
// - States and transitions:
//   - IDLE -> ISSUE on start.
//   - ISSUE -> DRAIN after address NUM_WORDS-1 is issued.
//   - DRAIN -> IDLE when the last pair handshakes. done pulses on the following cycle.
// - Issue rule:
//   - In ISSUE, an address is issued in a cycle when fifo_count + inflight - pop < 2.
//   - pop = out_valid & out_ready.
//   - rom_addr holds its value in cycles where no address is issued.
// - Issue pipeline:
//   - The inflight bit is set on each issue.
//   - One cycle after an issue, rom_data (with a last tag) is pushed into the 2-entry FIFO.
// - Latency:
//   - Start sampled at edge k puts rom_addr=0 out at k.
//   - ROM data is registered at k+1.
//   - out_valid rises after edge k+2.
// - Throughput: 1 pair/clk with out_ready held high. A full sweep (64 pairs) ends with done 66 cycles after start.
// - Output stability: while out_valid=1 and out_ready=0, out_idx_* and out_last hold stable.
// - FIFO boundaries:
//   - Push and pop in the same cycle are both honoured, including when full.
//   - The credit rule guarantees no push ever occurs when full without a pop. Assert this.
// - start while busy is ignored.
// - start in the same cycle as the done pulse is accepted, since the FSM is already IDLE.
// - The counter never wraps inside a run. rom_addr returns to 0 only on the next accepted start.
// STRUCTURE
// - Shared package kyber_ntt_pkg holds:
//   - localparams KY_ADDR_W=6, KY_IDX_W=8, KY_NUM_WORDS=64;
//   - typedef state_e {IDLE, ISSUE, DRAIN}.
// - One sub-module: pair_fifo2, a 2-entry synchronous FIFO (data + last tag) with count output.
// - The FSM, issue counter and inflight bit stay in this module.
// TESTING
// - ROM model returns {2a, 2a+1}. With out_ready=1, pulse start:
//   - 64 pairs emitted in order, (0,1) through (126,127);
//   - out_last set only with (126,127);
//   - done pulses exactly once, 66 clks after start.
// - Random out_ready (50%): same 64 pairs arrive in order with no loss or duplication.
//   Payload stays stable while stalled, and the FIFO-overflow assertion never fires.
// - out_ready=0 for 20 cycles after start:
//   - at most 2 pairs buffered;
//   - rom_addr advances no further than 2;
//   - releasing ready resumes at pair (4,5) after (0,1),(2,3).
// - start pulsed again mid-run (at pair 10): ignored, busy stays high, total is still 64 pairs.
// - rst asserted at pair 30: next cycle all outputs are at reset values with no done pulse.
//   A new start then restarts from (0,1).
// - start asserted in the done cycle: the second sweep begins immediately and also yields 64 pairs.

Source files
------------

// File: rtl/kyber_ntt_pkg.sv
// Shared constants and types for the NTT coefficient-index fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package kyber_ntt_pkg;

    localparam int KY_ADDR_W    = 6;
    localparam int KY_IDX_W     = 8;
    localparam int KY_NUM_WORDS = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pair_fifo2.sv
// Two-entry synchronous FIFO holding one index pair plus its last tag per entry.
// Latency: a push is visible at the head one cycle later; the head is read combinationally.
// Backpressure: push and pop in one cycle are both honoured even when full; the
//   producer's credit scheme must never push into a full FIFO without a pop.
// Ports: clk_i/rst_i (sync, active-high), push_i/push_dat_i write side,
//   pop_i read side, head_dat_o oldest entry, count_o occupancy 0..2.
module pair_fifo2 #(
    parameter int W = 17
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    overflow_chk: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && (count_q == 2'd2) && !pop_i));

endmodule

// File: rtl/inout_pair_sequencer.sv
// Sweeps the index-pair ROM once per start and streams each word as an even/odd index pair.
// Latency: start at edge k -> rom_addr=0 at k, ROM data at k+1, out_valid after k+2;
//   done pulses the cycle after the final pair handshakes.
// Backpressure: address issue is credit-limited so the 2-entry FIFO never overflows;
//   a stalled pair holds its payload and nothing is dropped or duplicated.
// Ports: clk/rst (sync, active-high); start/busy/done control; rom_addr/rom_data ROM side;
//   out_valid/out_ready/out_idx_hi/out_idx_lo/out_last downstream pair stream.
module inout_pair_sequencer
    import kyber_ntt_pkg::*;
#(
    parameter int ADDR_W    = KY_ADDR_W,
    parameter int IDX_W     = KY_IDX_W,
    parameter int NUM_WORDS = KY_NUM_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [2*IDX_W-1:0] rom_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDX_W-1:0]   out_idx_hi,
    output logic [IDX_W-1:0]   out_idx_lo,
    output logic               out_last
);

    localparam int                DW        = 2 * IDX_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              done_q, done_d;

    logic [DW:0]       head_dat;
    logic [1:0]        fifo_count;
    logic              head_vld;
    logic              head_last;
    logic              pop;
    logic              issue;
    logic              at_last_addr;
    logic [2:0]        occupancy;

    assign head_vld     = (fifo_count != 2'd0);
    assign head_last    = head_dat[DW];
    assign pop          = head_vld & out_ready;
    assign at_last_addr = (rom_addr_q == LAST_ADDR);

    // Buffered plus in-flight pairs must stay below the FIFO depth after this
    // cycle's pop, so the word arriving next cycle always has a slot.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign issue     = (state_q == ISSUE) && (occupancy < (3'd2 + {2'b00, pop}));

    // inflight_q marks that rom_data this cycle belongs to an issued address.
    pair_fifo2 #(
        .W (DW + 1)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (inflight_q),
        .push_dat_i ({inflight_last_q, rom_data}),
        .pop_i      (pop),
        .head_dat_o (head_dat),
        .count_o    (fifo_count)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)                 state_d = ISSUE;
            ISSUE:   if (issue && at_last_addr) state_d = DRAIN;
            DRAIN:   if (pop && head_last)      state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Issue counter and pipeline tags. The counter parks on the last address
    // instead of wrapping; only an accepted start brings it back to 0.
    always_comb begin
        rom_addr_d = rom_addr_q;
        if ((state_q == IDLE) && start) begin
            rom_addr_d = '0;
        end else if (issue && !at_last_addr) begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
        end
        inflight_d      = issue;
        inflight_last_d = issue & at_last_addr;
        done_d          = (state_q == DRAIN) & pop & head_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q      <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            rom_addr_q      <= rom_addr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    // Output logic; payload is forced to zero whenever no pair is offered.
    always_comb begin
        busy       = (state_q != IDLE);
        done       = done_q;
        rom_addr   = rom_addr_q;
        out_valid  = head_vld;
        out_idx_hi = head_vld ? head_dat[DW-1:IDX_W] : '0;
        out_idx_lo = head_vld ? head_dat[IDX_W-1:0]  : '0;
        out_last   = head_vld & head_last;
    end

endmodule

// File: tb/tb_inout_pair_sequencer.sv
module tb_inout_pair_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_last;
    logic [5:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [7:0]  out_idx_hi;
    logic [7:0]  out_idx_lo;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pair_n   = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int t;
    logic        stalled = 1'b0;
    logic [16:0] held    = '0;

    always #5 clk = ~clk;

    // ROM model: word at address a is {2a, 2a+1}, registered one cycle.
    always @(posedge clk) rom_data <= {8'(2 * rom_addr), 8'(2 * rom_addr + 1)};

    inout_pair_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx_hi (out_idx_hi),
        .out_idx_lo (out_idx_lo),
        .out_last   (out_last)
    );

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Observe the current cycle (inputs already applied), then advance one edge.
    task automatic step();
        if (stalled) begin
            chk_eq("stall_valid", 32'(out_valid), 32'd1);
            chk_eq("stall_payload", 32'({out_last, out_idx_hi, out_idx_lo}), 32'(held));
        end
        if (out_valid && out_ready) begin
            chk_eq("pair_hi", 32'(out_idx_hi), 32'(2 * pair_n));
            chk_eq("pair_lo", 32'(out_idx_lo), 32'(2 * pair_n + 1));
            chk_eq("pair_last", 32'(out_last), 32'(pair_n == 63));
            pair_n++;
        end
        stalled = out_valid && !out_ready;
        held    = {out_last, out_idx_hi, out_idx_lo};
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_run();
        pair_n   = 0;
        done_cnt = 0;
        stalled  = 1'b0;
    endtask

    task automatic pulse_start(input logic rdy);
        out_ready = rdy;
        start     = 1'b1;
        step();
        start     = 1'b0;
        start_cyc = cyc;
        chk_eq("start_addr", 32'(rom_addr), 32'd0);
        chk_eq("start_busy", 32'(busy), 32'd1);
    endtask

    task automatic chk_reset(input string pfx);
        chk_eq({pfx, "_addr"},  32'(rom_addr),   32'd0);
        chk_eq({pfx, "_busy"},  32'(busy),       32'd0);
        chk_eq({pfx, "_done"},  32'(done),       32'd0);
        chk_eq({pfx, "_valid"}, 32'(out_valid),  32'd0);
        chk_eq({pfx, "_hi"},    32'(out_idx_hi), 32'd0);
        chk_eq({pfx, "_lo"},    32'(out_idx_lo), 32'd0);
        chk_eq({pfx, "_last"},  32'(out_last),   32'd0);
    endtask

    task automatic wait_done(input bit rand_ready, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            step();
        end
        chk_eq("done_once", 32'(done_cnt), 32'd1);
        chk_eq("pair_total", 32'(pair_n), 32'd64);
        chk_eq("busy_after", 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b0;
        step();

        // Full-rate sweep: 64 ordered pairs, done 66 cycles after start.
        begin_run();
        pulse_start(1'b1);
        wait_done(1'b0, 200);
        chk_eq("done_latency", 32'(done_cyc - start_cyc), 32'd66);

        // Random back-pressure: ordering and stall stability checked per cycle.
        begin_run();
        pulse_start(1'b1);
        wait_done(1'b1, 1000);

        // Downstream stalled for 20 cycles: only two words fetched and buffered.
        begin_run();
        pulse_start(1'b0);
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'b0;
            step();
            chk_eq("stall_addr_bound", 32'(rom_addr <= 6'd2), 32'd1);
        end
        chk_eq("stall_addr", 32'(rom_addr), 32'd2);
        chk_eq("stall_fifo_count", 32'(dut.u_fifo.count_o), 32'd2);
        chk_eq("stall_head_hi", 32'(out_idx_hi), 32'd0);
        chk_eq("stall_pairs", 32'(pair_n), 32'd0);
        wait_done(1'b0, 200);

        // start pulsed mid-run is ignored.
        begin_run();
        pulse_start(1'b1);
        t = 0;
        while (pair_n < 10 && t < 100) begin
            step();
            t++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk_eq("restart_busy", 32'(busy), 32'd1);
        chk_eq("restart_ignored", 32'(rom_addr == 6'd0), 32'd0);
        wait_done(1'b0, 200);
        chk_eq("restart_latency", 32'(done_cyc - start_cyc), 32'd66);

        // Reset mid-run aborts without a done pulse; next start begins at (0,1).
        begin_run();
        pulse_start(1'b1);
        t = 0;
        while (pair_n < 30 && t < 100) begin
            step();
            t++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("abort");
        done_cnt = 0;
        repeat (5) step();
        chk_eq("abort_no_done", 32'(done_cnt), 32'd0);
        begin_run();
        pulse_start(1'b1);
        wait_done(1'b0, 200);

        // start in the done cycle launches the next sweep at once.
        begin_run();
        pulse_start(1'b1);
        t = 0;
        while (done !== 1'b1 && t < 200) begin
            step();
            t++;
        end
        chk_eq("b2b_first_total", 32'(pair_n), 32'd64);
        chk_eq("b2b_first_latency", 32'(cyc - start_cyc), 32'd66);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_eq("b2b_busy", 32'(busy), 32'd1);
        chk_eq("b2b_addr", 32'(rom_addr), 32'd0);
        begin_run();
        start_cyc = cyc;
        wait_done(1'b0, 200);
        chk_eq("b2b_second_latency", 32'(done_cyc - start_cyc), 32'd66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
